lsu_riscv: RTL and testbench

- Load/store unit between the core execute stage and the data-memory bus. Consumes the memory-access controls the instruction decoder produces: request, write-enable and size in LDST_* encoding.
- Aligns and byte-lane-steers store data and sign/zero-extends load data.
- Runs a req/gnt/rvalid bus handshake and stalls the core until the access completes.
- Flags misaligned or illegal accesses and bus timeouts.

---
 rtl/lsu_riscv_if.sv | 22 ++
 rtl/lsu_riscv.sv | 149 ++++++++++++++
 tb/tb_lsu_riscv.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_riscv_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Uses a req/gnt/rvalid handshake with word addresses and byte enables.
interface lsu_riscv_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;

  modport master (
    output data_req, data_we, data_be, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_be, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/lsu_riscv.sv
// Load/store unit: steers store lanes, extends load data, runs the req/gnt/rvalid
// bus handshake, stalls the core until completion and flags bad accesses/timeouts.
module lsu_riscv #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_data_i,
  output logic [31:0] lsu_data_o,
  output logic        lsu_stall_req_o,
  output logic        lsu_err_o,
  lsu_riscv_if.master bus
);

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_bad;
  logic               w_timeout;
  logic               w_complete;
  logic               w_err;
  logic               w_req;

  function automatic logic [3:0] f_be(input logic [2:0] size, input logic [1:0] a);
    case (size)
      LDST_B, LDST_BU: return 4'b0001 << a;
      LDST_H, LDST_HU: return a[1] ? 4'b1100 : 4'b0011;
      LDST_W:          return 4'b1111;
      default:         return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] size, input logic [31:0] d);
    case (size)
      LDST_B, LDST_BU: return {4{d[7:0]}};
      LDST_H, LDST_HU: return {2{d[15:0]}};
      default:         return d;
    endcase
  endfunction

  // Sign extension is done by assigning signed narrow values to a signed word.
  function automatic logic [31:0] f_load(input logic [2:0] size, input logic [1:0] a,
                                         input logic [31:0] rdata);
    logic        [7:0]  byte_u;
    logic        [15:0] half_u;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] ext_s;
    byte_u = rdata[8*a +: 8];
    half_u = a[1] ? rdata[31:16] : rdata[15:0];
    byte_s = byte_u;
    half_s = half_u;
    case (size)
      LDST_B:  begin ext_s = byte_s; return ext_s; end
      LDST_H:  begin ext_s = half_s; return ext_s; end
      LDST_BU: return {24'd0, byte_u};
      LDST_HU: return {16'd0, half_u};
      default: return rdata;
    endcase
  endfunction

  always_comb begin
    case (lsu_size_i)
      LDST_B:  w_bad = 1'b0;
      LDST_H:  w_bad = lsu_addr_i[0];
      LDST_W:  w_bad = (lsu_addr_i[1:0] != 2'b00);
      LDST_BU: w_bad = lsu_we_i;
      LDST_HU: w_bad = lsu_we_i | lsu_addr_i[0];
      default: w_bad = 1'b1;
    endcase
  end

  assign w_timeout = (r_state != IDLE) && (r_cnt >= CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    w_next     = r_state;
    w_req      = 1'b0;
    w_complete = 1'b0;
    w_err      = 1'b0;
    case (r_state)
      IDLE: begin
        if (lsu_req_i) begin
          if (w_bad) begin
            w_err = 1'b1;
          end else begin
            w_req  = 1'b1;
            w_next = bus.data_gnt ? RESP : REQ;
          end
        end
      end
      REQ: begin
        if (w_timeout) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end else begin
          w_req = 1'b1;
          if (bus.data_gnt) w_next = RESP;
        end
      end
      RESP: begin
        if (w_timeout) begin
          w_err  = 1'b1;
          w_next = IDLE;
        end else if (bus.data_rvalid) begin
          w_complete = 1'b1;
          w_next     = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // State and timeout counter; the counter restarts every time the FSM leaves IDLE.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (r_state == IDLE) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Handshake outputs are forced low while reset is held, whatever the old state.
  assign bus.data_req    = rst_n_i & w_req;
  assign lsu_err_o       = rst_n_i & w_err;
  assign lsu_stall_req_o = rst_n_i & lsu_req_i & ~(w_complete | w_err);
  assign lsu_data_o      = (rst_n_i && w_complete && !lsu_we_i)
                           ? f_load(lsu_size_i, lsu_addr_i[1:0], bus.data_rdata) : 32'd0;

  assign bus.data_we    = lsu_we_i;
  assign bus.data_be    = f_be(lsu_size_i, lsu_addr_i[1:0]);
  assign bus.data_addr  = {lsu_addr_i[31:2], 2'b00};
  assign bus.data_wdata = f_wdata(lsu_size_i, lsu_data_i);

endmodule

// File: tb/tb_lsu_riscv.sv
// Directed bench for lsu_riscv: loads, stores, bad accesses, timeout and reset abort.
module tb_lsu_riscv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we;
  logic [2:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        stall, err;
  int          nvec = 0;
  int          nerr = 0;

  lsu_riscv_if bus ();

  lsu_riscv #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .lsu_req_i      (lsu_req),
    .lsu_we_i       (lsu_we),
    .lsu_size_i     (lsu_size),
    .lsu_addr_i     (lsu_addr),
    .lsu_data_i     (lsu_wdata),
    .lsu_data_o     (lsu_rdata),
    .lsu_stall_req_o(stall),
    .lsu_err_o      (err),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] data);
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = data;
  endtask

  task automatic idle_bus();
    lsu_req = 1'b0; bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0; bus.data_rdata = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    set_req(1'b0, 3'd2, 32'h0000_0104, 32'd0);
    @(negedge clk);
    nvec++; if (bus.data_req !== 1'b0) begin $display("FAIL rst_req got %b want 0", bus.data_req); nerr++; end
    nvec++; if (stall !== 1'b0) begin $display("FAIL rst_stall got %b want 0", stall); nerr++; end
    nvec++; if (err !== 1'b0) begin $display("FAIL rst_err got %b want 0", err); nerr++; end
    nvec++; if (lsu_rdata !== 32'd0) begin $display("FAIL rst_data got %h want 0", lsu_rdata); nerr++; end
    tick();
    rst_n = 1'b1;
    lsu_req = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    set_req(1'b0, 3'd2, 32'h0000_0104, 32'd0);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    nvec++; if (bus.data_req !== 1'b1) begin $display("FAIL lw_req got %b want 1", bus.data_req); nerr++; end
    nvec++; if (bus.data_addr !== 32'h104) begin $display("FAIL lw_addr got %h want 104", bus.data_addr); nerr++; end
    nvec++; if (bus.data_be !== 4'b1111) begin $display("FAIL lw_be got %b want 1111", bus.data_be); nerr++; end
    nvec++; if (bus.data_we !== 1'b0) begin $display("FAIL lw_we got %b want 0", bus.data_we); nerr++; end
    nvec++; if (stall !== 1'b1) begin $display("FAIL lw_stall0 got %b want 1", stall); nerr++; end
    tick();
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    nvec++; if (bus.data_req !== 1'b0) begin $display("FAIL lw_req1 got %b want 0", bus.data_req); nerr++; end
    nvec++; if (stall !== 1'b0) begin $display("FAIL lw_stall1 got %b want 0", stall); nerr++; end
    nvec++; if (lsu_rdata !== 32'hDEAD_BEEF) begin $display("FAIL lw_data got %h want deadbeef", lsu_rdata); nerr++; end
    tick();
    idle_bus();
    @(negedge clk);
    nvec++; if (lsu_rdata !== 32'd0) begin $display("FAIL lw_data_idle got %h want 0", lsu_rdata); nerr++; end
    tick();
  endtask

  task automatic test_lb(input logic [2:0] size, input logic [31:0] exp);
    set_req(1'b0, size, 32'h0000_0103, 32'd0);
    @(negedge clk);
    nvec++; if (bus.data_be !== 4'b1000) begin $display("FAIL lb_be size%0d got %b want 1000", size, bus.data_be); nerr++; end
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin bus.data_rvalid = 1'b1; bus.data_rdata = 32'h1234_5678; end
      else bus.data_rvalid = 1'b0;
      @(negedge clk);
      nvec++; if (bus.data_req !== 1'b1) begin $display("FAIL lb_req c%0d got %b want 1", c, bus.data_req); nerr++; end
      nvec++; if (stall !== 1'b1) begin $display("FAIL lb_stall c%0d got %b want 1", c, stall); nerr++; end
      nvec++; if (lsu_rdata !== 32'd0) begin $display("FAIL lb_early_data c%0d got %h want 0", c, lsu_rdata); nerr++; end
      tick();
    end
    bus.data_rvalid = 1'b0; bus.data_gnt = 1'b1;
    @(negedge clk);
    nvec++; if (bus.data_req !== 1'b1) begin $display("FAIL lb_req_gnt got %b want 1", bus.data_req); nerr++; end
    tick();
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h80FF_0000;
    @(negedge clk);
    nvec++; if (stall !== 1'b0) begin $display("FAIL lb_stall_done got %b want 0", stall); nerr++; end
    nvec++; if (lsu_rdata !== exp) begin $display("FAIL lb_data size%0d got %h want %h", size, lsu_rdata, exp); nerr++; end
    tick();
    idle_bus();
    tick();
  endtask

  task automatic test_back_to_back();
    set_req(1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    nvec++; if (bus.data_we !== 1'b1) begin $display("FAIL sh_we got %b want 1", bus.data_we); nerr++; end
    nvec++; if (bus.data_be !== 4'b1100) begin $display("FAIL sh_be got %b want 1100", bus.data_be); nerr++; end
    nvec++; if (bus.data_wdata !== 32'hABCD_ABCD) begin $display("FAIL sh_wdata got %h want abcdabcd", bus.data_wdata); nerr++; end
    nvec++; if (bus.data_addr !== 32'h200) begin $display("FAIL sh_addr got %h want 200", bus.data_addr); nerr++; end
    tick();
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    nvec++; if (stall !== 1'b0) begin $display("FAIL sh_stall_done got %b want 0", stall); nerr++; end
    nvec++; if (lsu_rdata !== 32'd0) begin $display("FAIL sh_data got %h want 0", lsu_rdata); nerr++; end
    tick();
    set_req(1'b1, 3'd0, 32'h0000_0101, 32'h0000_0055);
    bus.data_rvalid = 1'b0; bus.data_gnt = 1'b1;
    @(negedge clk);
    nvec++; if (bus.data_req !== 1'b1) begin $display("FAIL sb_req got %b want 1", bus.data_req); nerr++; end
    nvec++; if (bus.data_be !== 4'b0010) begin $display("FAIL sb_be got %b want 0010", bus.data_be); nerr++; end
    nvec++; if (bus.data_wdata !== 32'h5555_5555) begin $display("FAIL sb_wdata got %h want 55555555", bus.data_wdata); nerr++; end
    tick();
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1;
    @(negedge clk);
    nvec++; if (stall !== 1'b0) begin $display("FAIL sb_stall_done got %b want 0", stall); nerr++; end
    tick();
    idle_bus();
    tick();
  endtask

  task automatic test_bad();
    logic        we_t   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  size_t [4] = '{3'd2, 3'd1, 3'd4, 3'd3};
    logic [31:0] addr_t [4] = '{32'h101, 32'h001, 32'h100, 32'h100};
    for (int i = 0; i < 4; i++) begin
      set_req(we_t[i], size_t[i], addr_t[i], 32'hA5A5_A5A5);
      bus.data_gnt = 1'b1;
      @(negedge clk);
      nvec++; if (bus.data_req !== 1'b0) begin $display("FAIL bad%0d_req got %b want 0", i, bus.data_req); nerr++; end
      nvec++; if (err !== 1'b1) begin $display("FAIL bad%0d_err got %b want 1", i, err); nerr++; end
      nvec++; if (stall !== 1'b0) begin $display("FAIL bad%0d_stall got %b want 0", i, stall); nerr++; end
      tick();
      idle_bus();
      @(negedge clk);
      nvec++; if (err !== 1'b0) begin $display("FAIL bad%0d_err_pulse got %b want 0", i, err); nerr++; end
      tick();
    end
  endtask

  task automatic test_timeout();
    set_req(1'b0, 3'd2, 32'h0000_0010, 32'd0);
    bus.data_gnt = 1'b1;
    tick();
    bus.data_gnt = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (err !== 1'b0 || stall !== 1'b1) begin
        $display("FAIL to_wait c%0d err %b stall %b want 0 1", c, err, stall); nerr++;
      end
      nvec++;
      tick();
    end
    @(negedge clk);
    nvec++; if (err !== 1'b1) begin $display("FAIL to_err got %b want 1", err); nerr++; end
    nvec++; if (stall !== 1'b0) begin $display("FAIL to_stall got %b want 0", stall); nerr++; end
    nvec++; if (bus.data_req !== 1'b0) begin $display("FAIL to_req got %b want 0", bus.data_req); nerr++; end
    tick();
    idle_bus();
    @(negedge clk);
    nvec++; if (err !== 1'b0) begin $display("FAIL to_err_after got %b want 0", err); nerr++; end
    tick();
    set_req(1'b0, 3'd2, 32'h0000_0014, 32'd0);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    nvec++; if (bus.data_req !== 1'b1) begin $display("FAIL to_next_req got %b want 1", bus.data_req); nerr++; end
    tick();
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    nvec++; if (lsu_rdata !== 32'hCAFE_F00D) begin $display("FAIL to_next_data got %h want cafef00d", lsu_rdata); nerr++; end
    tick();
    idle_bus();
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1'b0, 3'd2, 32'h0000_0020, 32'd0);
    bus.data_gnt = 1'b1;
    tick();
    bus.data_gnt = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    nvec++; if (stall !== 1'b0) begin $display("FAIL rm_stall got %b want 0", stall); nerr++; end
    nvec++; if (bus.data_req !== 1'b0) begin $display("FAIL rm_req got %b want 0", bus.data_req); nerr++; end
    tick();
    rst_n = 1'b1;
    lsu_req = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h1111_1111;
    @(negedge clk);
    nvec++; if (lsu_rdata !== 32'd0) begin $display("FAIL rm_late_data got %h want 0", lsu_rdata); nerr++; end
    nvec++; if (err !== 1'b0) begin $display("FAIL rm_late_err got %b want 0", err); nerr++; end
    tick();
    bus.data_rvalid = 1'b0;
    set_req(1'b0, 3'd1, 32'h0000_0022, 32'd0);
    bus.data_gnt = 1'b1;
    @(negedge clk);
    nvec++; if (stall !== 1'b1) begin $display("FAIL rm_lh_stall got %b want 1", stall); nerr++; end
    tick();
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b1; bus.data_rdata = 32'h8001_7FFF;
    @(negedge clk);
    nvec++; if (lsu_rdata !== 32'hFFFF_8001) begin $display("FAIL rm_lh_data got %h want ffff8001", lsu_rdata); nerr++; end
    tick();
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lb(3'd0, 32'hFFFF_FF80);
    test_lb(3'd4, 32'h0000_0080);
    test_back_to_back();
    test_bad();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
